oam_dma_controller: RTL and testbench
=====================================

Name: oam_dma_controller

Overview:
- Sprite OAM DMA sequencer and CPU-bus arbiter.
- A CPU write to $4014 with value PP stalls the CPU and takes the external address/data bus. It then copies $PP00-$PPFF into PPU OAMDATA ($2004) as 256 read/write pairs, and returns the bus to the CPU.
- Sits between CPU (Addr_bus/Data_bus_out/R_nW) and the system memory map.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU write address that triggers a transfer.
- DEST_ADDR, 16'h2004, destination address written once per byte.
- ALIGN_EN, 1, 1 = insert an alignment cycle so every READ lands on an even cycle; 0 = never align.

Ports:
- clk_ph1 input 1: sole clock; all state updates on posedge.
- rst input 1: asynchronous, active-low reset.
- cpu_addr input 16: CPU address bus.
- cpu_dout input 8: CPU write data.
- cpu_r_nw input 1: CPU read/not-write.
- bus_din input 8: read data returned from the memory map.
- bus_addr output 16: arbitrated address to the memory map.
- bus_dout output 8: arbitrated write data.
- bus_r_nw output 1: arbitrated read/not-write.
- cpu_rdy output 1: 0 = CPU must hold its state this cycle.
- dma_active output 1: 1 whenever the DMA owns the bus.

Behaviour:
- States: IDLE, HALT, ALIGN, READ, WRITE. Encoded in 3 bits; no other reachable states, and unused codes go to IDLE.
- cyc_par: 1-bit free-running toggle every clk_ph1, reset 0.
- Trigger: in IDLE, a sample of cpu_r_nw=0 with cpu_addr=DMA_REG_ADDR latches page<=cpu_dout and idx<=0, and moves to HALT on the next edge. The triggering write itself passes through to the bus unmodified.
- HALT (1 cycle):
  - Drives a dummy read: bus_addr={page,8'h00}, bus_r_nw=1.
  - Next state is ALIGN if ALIGN_EN=1 and cyc_par=0 in this cycle; otherwise READ. This guarantees READ sees cyc_par=0.
- ALIGN (1 cycle): same dummy read as HALT; next state READ.
- READ: bus_addr={page,idx}, bus_r_nw=1. At the closing edge, data_reg<=bus_din; next state WRITE.
- WRITE: bus_addr=DEST_ADDR, bus_r_nw=0, bus_dout=data_reg. At the closing edge idx<=idx+1 (8-bit). If idx was 8'hFF, next state is IDLE; otherwise READ.
- Latency: trigger edge to return to IDLE is 513 cycles (no align) or 514 cycles (align). Exactly 256 WRITE cycles per transfer.
- Arbitration (combinational):
  - IDLE: bus_* = cpu_*; cpu_rdy=1; dma_active=0.
  - Any other state: bus_* driven by the DMA; cpu_rdy=0; dma_active=1.
  - bus_dout in DMA read states = data_reg (don't-care for the target).
- Page $20-$3F source: reads are passed through as normal bus reads, with no special casing.
- A $4014 write sampled while not IDLE is ignored; the CPU is stalled, so this is only reachable by forced stimulus.
- idx wraps within the page; the transfer never crosses into page PP+1.
- Reset (any time, including mid-transfer):
  - Registers: state=IDLE, page=0, idx=0, data_reg=0, cyc_par=0.
  - Outputs: cpu_rdy=1, dma_active=0, bus mux selects the CPU.
  - The aborted transfer is not resumed.
- A CPU read of $4014 does not trigger.

Decomposition:
- Shared header nes_defs.vh holds:
  - state encodings (ST_IDLE..ST_WRITE);
  - memory-map constants ADDR_OAMDMA=16'h4014 and ADDR_OAMDATA=16'h2004, reused by the PPU and bus decoder.
- No sub-module: a single FSM plus counter and a bus mux, about 150-250 lines.
- CPU integration (separate change): the CPU gates its phase-1 register updates and cycle counter with cpu_rdy.

Test Plan:
- Even-aligned transfer: with ALIGN_EN=1, issue the trigger so HALT sees cyc_par=1, using CPU write $4014<=8'h02 and memory $0200+i = i^8'h5A. Required: no ALIGN cycle; 256 writes to $2004 carrying data 8'h5A,8'h5B,..., in order; cpu_rdy low for exactly 513 cycles.
- Odd-aligned transfer: same write with HALT at cyc_par=0. Required: exactly one ALIGN cycle; 514 stalled cycles; every READ on cyc_par=0.
- Wrap boundary: page 8'h07. Required: last READ address $07FF; first READ address $0700; no access to $0800; IDLE immediately after the 256th write.
- Reset mid-transfer: assert rst low after 100 writes. Required: cpu_rdy=1, dma_active=0 and bus_addr=cpu_addr immediately (asynchronous); no further $2004 writes after rst is released.
- Non-trigger traffic: a CPU read of $4014, a write to $4015, and a write to $4014 during DMA. Required: none starts a new transfer; bus_* mirrors cpu_* in IDLE.
- Back-to-back: a second $4014 write (8'h03) issued 2 cycles after the first transfer completes. Required: a full second transfer from $0300 with correct alignment, and the write count totals 512.

Source files
------------

// File: rtl/oam_dma_controller_pkg.sv
// Shared memory-map constants and DMA sequencer state encodings.
// Reused by the PPU and bus decoder for the $2004/$4014 decode.
package oam_dma_controller_pkg;

    localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
    localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } dma_state_e;

endpackage

// File: rtl/oam_dma_controller.sv
// Sprite OAM DMA sequencer: on a $4014 write, stalls the CPU and copies page PP
// into OAMDATA as 256 read/write pairs, then hands the bus back.
module oam_dma_controller
    import oam_dma_controller_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = ADDR_OAMDMA,
    parameter logic [15:0] DEST_ADDR    = ADDR_OAMDATA,
    parameter bit          ALIGN_EN     = 1'b1
) (
    input  logic        clk_ph1,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_r_nw,
    input  logic [7:0]  bus_din,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    output logic        bus_r_nw,
    output logic        cpu_rdy,
    output logic        dma_active
);

    dma_state_e state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;
    logic       cyc_par_q;

    always_ff @(posedge clk_ph1 or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            page_q    <= 8'h00;
            idx_q     <= 8'h00;
            data_q    <= 8'h00;
            cyc_par_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            page_q    <= page_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            cyc_par_q <= ~cyc_par_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        idx_d      = idx_q;
        data_d     = data_q;
        bus_addr   = cpu_addr;
        bus_dout   = cpu_dout;
        bus_r_nw   = cpu_r_nw;
        cpu_rdy    = 1'b1;
        dma_active = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // The triggering write itself still reaches the bus untouched.
                if (!cpu_r_nw && (cpu_addr == DMA_REG_ADDR)) begin
                    page_d  = cpu_dout;
                    idx_d   = 8'h00;
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                bus_addr   = {page_q, 8'h00};
                bus_dout   = data_q;
                bus_r_nw   = 1'b1;
                cpu_rdy    = 1'b0;
                dma_active = 1'b1;
                // Pad one cycle when needed so every READ lands on cyc_par=0.
                state_d    = (ALIGN_EN && !cyc_par_q) ? ST_ALIGN : ST_READ;
            end
            ST_ALIGN: begin
                bus_addr   = {page_q, 8'h00};
                bus_dout   = data_q;
                bus_r_nw   = 1'b1;
                cpu_rdy    = 1'b0;
                dma_active = 1'b1;
                state_d    = ST_READ;
            end
            ST_READ: begin
                bus_addr   = {page_q, idx_q};
                bus_dout   = data_q;
                bus_r_nw   = 1'b1;
                cpu_rdy    = 1'b0;
                dma_active = 1'b1;
                data_d     = bus_din;
                state_d    = ST_WRITE;
            end
            ST_WRITE: begin
                bus_addr   = DEST_ADDR;
                bus_dout   = data_q;
                bus_r_nw   = 1'b0;
                cpu_rdy    = 1'b0;
                dma_active = 1'b1;
                idx_d      = idx_q + 8'd1;
                state_d    = (idx_q == 8'hFF) ? ST_IDLE : ST_READ;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma_controller.sv
// Scoreboard bench for oam_dma_controller: stimulus queues expected OAMDATA writes
// and stall lengths; a negedge monitor checks them as the DUT produces them.
module tb_oam_dma_controller;

    typedef struct packed {
        logic [15:0] rd_addr;
        logic [7:0]  data;
    } xfer_t;

    logic        clk_ph1 = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] cpu_addr = 16'h1234;
    logic [7:0]  cpu_dout = 8'hA5;
    logic        cpu_r_nw = 1'b1;
    logic [7:0]  bus_din;
    logic [15:0] bus_addr;
    logic [7:0]  bus_dout;
    logic        bus_r_nw;
    logic        cpu_rdy;
    logic        dma_active;

    xfer_t       sb[$];
    int          stall_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          write_cnt = 0;
    int          stall_cnt = 0;
    logic [7:0]  exp_page = 8'h00;
    logic        par;
    logic [15:0] prev_addr = 16'h0000;
    logic        prev_rnw = 1'b1;
    logic        prev_par = 1'b0;
    logic        prev_dma = 1'b0;

    oam_dma_controller dut (
        .clk_ph1    (clk_ph1),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .cpu_r_nw   (cpu_r_nw),
        .bus_din    (bus_din),
        .bus_addr   (bus_addr),
        .bus_dout   (bus_dout),
        .bus_r_nw   (bus_r_nw),
        .cpu_rdy    (cpu_rdy),
        .dma_active (dma_active)
    );

    always #5 clk_ph1 = ~clk_ph1;

    // Memory model: byte at $PPii holds ii ^ 8'h5A for every page.
    assign bus_din = bus_addr[7:0] ^ 8'h5A;

    // Independent cycle-parity model.
    always @(posedge clk_ph1 or negedge rst) begin
        if (!rst) par <= 1'b0;
        else      par <= ~par;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitor
    always @(negedge clk_ph1) begin
        xfer_t e;
        if (!rst) begin
            sb.delete();
            stall_q.delete();
            stall_cnt = 0;
            prev_dma  = 1'b0;
        end else begin
            if (dma_active) begin
                check("stall cpu_rdy", {31'd0, cpu_rdy}, 32'd0);
                stall_cnt++;
                if (bus_r_nw || bus_addr != 16'h2004)
                    check("dma page", {24'd0, bus_addr[15:8]}, {24'd0, exp_page});
                if (!bus_r_nw) begin
                    write_cnt++;
                    if (sb.size() == 0) begin
                        flag("unexpected oamdata write");
                    end else begin
                        e = sb.pop_front();
                        check("write addr", {16'd0, bus_addr}, 32'h2004);
                        check("write data", {24'd0, bus_dout}, {24'd0, e.data});
                        check("read addr", {16'd0, prev_addr}, {16'd0, e.rd_addr});
                        check("read r_nw", {31'd0, prev_rnw}, 32'd1);
                        check("read parity", {31'd0, prev_par}, 32'd0);
                    end
                end
            end else begin
                check("idle cpu_rdy", {31'd0, cpu_rdy}, 32'd1);
                check("idle addr mirror", {16'd0, bus_addr}, {16'd0, cpu_addr});
                check("idle dout mirror", {24'd0, bus_dout}, {24'd0, cpu_dout});
                check("idle r_nw mirror", {31'd0, bus_r_nw}, {31'd0, cpu_r_nw});
                if (prev_dma) begin
                    if (stall_q.size() == 0) flag("unexpected stall");
                    else check("stall length", stall_cnt, stall_q.pop_front());
                    check("writes left at idle", sb.size(), 32'd0);
                end
                stall_cnt = 0;
            end
            prev_addr = bus_addr;
            prev_rnw  = bus_r_nw;
            prev_par  = par;
            prev_dma  = dma_active;
        end
    end

    task automatic idle_cycle();
        @(posedge clk_ph1); #1;
        cpu_addr = 16'h0000;
        cpu_r_nw = 1'b1;
        cpu_dout = 8'h00;
    endtask

    // want_par < 0: issue at once; otherwise wait until the sampling cycle has that parity.
    task automatic start_dma(input logic [7:0] pg, input int want_par);
        @(posedge clk_ph1); #1;
        if (want_par >= 0) begin
            while (par !== want_par[0]) begin
                @(posedge clk_ph1); #1;
            end
        end
        exp_page = pg;
        for (int i = 0; i < 256; i++) begin
            xfer_t e;
            e.rd_addr = {pg, i[7:0]};
            e.data    = i[7:0] ^ 8'h5A;
            sb.push_back(e);
        end
        // HALT sees ~par; an ALIGN cycle is added only when that is 0.
        stall_q.push_back(par ? 514 : 513);
        cpu_addr = 16'h4014;
        cpu_r_nw = 1'b0;
        cpu_dout = pg;
        @(posedge clk_ph1); #1;
        cpu_addr = 16'h0000;
        cpu_r_nw = 1'b1;
        cpu_dout = 8'h00;
        check("dma started", {31'd0, dma_active}, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (dma_active && n < 2000) begin
            @(posedge clk_ph1); #1;
            n++;
        end
        if (dma_active) flag("timeout waiting for idle");
    endtask

    task automatic wait_writes(input int target);
        int n = 0;
        while (write_cnt < target && n < 2000) begin
            @(posedge clk_ph1); #1;
            n++;
        end
        if (write_cnt < target) flag("timeout waiting for writes");
    endtask

    initial begin
        int base;

        // Reset state
        #12;
        check("reset cpu_rdy", {31'd0, cpu_rdy}, 32'd1);
        check("reset dma_active", {31'd0, dma_active}, 32'd0);
        check("reset addr mirror", {16'd0, bus_addr}, 32'h1234);
        check("reset dout mirror", {24'd0, bus_dout}, 32'hA5);
        @(posedge clk_ph1); #1;
        rst = 1'b1;
        repeat (3) idle_cycle();

        // Even-aligned: HALT at cyc_par=1, no ALIGN, 513 stalled cycles
        start_dma(8'h02, 0);
        wait_idle();
        repeat (3) idle_cycle();

        // Odd-aligned: HALT at cyc_par=0, one ALIGN, 514 stalled cycles
        start_dma(8'h02, 1);
        wait_idle();
        repeat (3) idle_cycle();

        // Wrap boundary within page $07
        start_dma(8'h07, -1);
        wait_idle();
        repeat (3) idle_cycle();

        // Non-trigger traffic: read of $4014, write to $4015
        @(posedge clk_ph1); #1;
        cpu_addr = 16'h4014; cpu_r_nw = 1'b1; cpu_dout = 8'h02;
        repeat (3) begin
            @(posedge clk_ph1); #1;
            check("read 4014 no trigger", {31'd0, dma_active}, 32'd0);
        end
        cpu_addr = 16'h4015; cpu_r_nw = 1'b0; cpu_dout = 8'h02;
        repeat (3) begin
            @(posedge clk_ph1); #1;
            check("write 4015 no trigger", {31'd0, dma_active}, 32'd0);
        end
        idle_cycle();

        // $4014 write forced during an active transfer is ignored
        base = write_cnt;
        start_dma(8'h04, -1);
        wait_writes(base + 50);
        cpu_addr = 16'h4014; cpu_r_nw = 1'b0; cpu_dout = 8'h66;
        repeat (5) @(posedge clk_ph1);
        #1;
        cpu_addr = 16'h0000; cpu_r_nw = 1'b1; cpu_dout = 8'h00;
        wait_idle();
        repeat (5) idle_cycle();
        check("no retrigger", {31'd0, dma_active}, 32'd0);
        check("forced-write transfer count", write_cnt - base, 32'd256);

        // Back-to-back transfers
        base = write_cnt;
        start_dma(8'h01, -1);
        wait_idle();
        idle_cycle();
        start_dma(8'h03, -1);
        wait_idle();
        check("back-to-back write total", write_cnt - base, 32'd512);
        repeat (3) idle_cycle();

        // Reset mid-transfer
        base = write_cnt;
        start_dma(8'h06, -1);
        wait_writes(base + 100);
        @(posedge clk_ph1); #2;
        cpu_addr = 16'h1357; cpu_r_nw = 1'b1; cpu_dout = 8'h3C;
        rst = 1'b0;
        #1;
        check("async rst cpu_rdy", {31'd0, cpu_rdy}, 32'd1);
        check("async rst dma_active", {31'd0, dma_active}, 32'd0);
        check("async rst addr mirror", {16'd0, bus_addr}, 32'h1357);
        @(posedge clk_ph1); #1;
        rst = 1'b1;
        base = write_cnt;
        repeat (30) idle_cycle();
        check("no writes after reset", write_cnt - base, 32'd0);
        check("idle after reset", {31'd0, dma_active}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
